simple_mem_slave: RTL and testbench
===================================

SIMPLE_MEM_SLAVE -- requirements
Module: simple_mem_slave

Interface
REQ-001 Parameter DW, default 32: data width in bits; legal values 32 or 64.
REQ-002 Parameter DEPTH, default 1024: number of DW-wide words; power of two.
REQ-003 Parameter WAIT, default 0: wait states inserted before acknowledge; range 0..15.
REQ-004 Parameter BASE, default 32'h0000_0000: byte base address of the memory window.
REQ-005 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  clock, all logic on rising edge.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 addr  in  32  byte address.
REQ-009 wd  in  DW  write data, lane-aligned (byte n of a word on bits 8n+7:8n).
REQ-010 we  in  1  1 = write, 0 = read.
REQ-011 size  in  2  0 = byte, 1 = half, 2 = word (32 bit), 3 = dword (64 bit).
REQ-012 req  in  1  request; held with addr/wd/we/size stable until req_ack.
REQ-013 rd  out  DW  read data, full aligned word, lane-aligned, valid only while req_ack = 1.
REQ-014 req_ack  out  1  one-cycle acknowledge pulse.
REQ-015 err  out  1  error flag, valid only while req_ack = 1.

Function
REQ-016 FSM states: IDLE, WAIT, ACK; encoding is a package enum.
REQ-017 IDLE: req = 1 -> WAIT if WAIT > 0, else ACK; the request is latched on that edge.
REQ-018 WAIT: counter loads WAIT-1 on entry, decrements each cycle, and moves to ACK at 0.
REQ-019 ACK: req_ack = 1 for exactly one cycle, then IDLE unconditionally.
REQ-020 Latency: req first high in cycle N -> req_ack high in cycle N+WAIT+1.
REQ-021 req high in the IDLE cycle after ACK starts a new transaction; the master drops req after req_ack to avoid this.
REQ-022 Offset = addr - BASE (32-bit unsigned); word index = offset >> log2(DW/8).
REQ-023 Error when any of: offset >= DEPTH*DW/8; addr not aligned to 2^size bytes; size = 3 with DW = 32.
REQ-024 On error: err = 1 with req_ack, rd = 0, and no array write.
REQ-025 Legal write: byte enables = ((1<<2^size)-1) << (addr mod DW/8); only enabled bytes change; the write commits on the ACK edge.
REQ-026 Legal read: rd = array word at the index, registered, presented in the ACK cycle; the master extracts its bytes.
REQ-027 Read-after-write to the same address in back-to-back transactions returns the new data.
REQ-028 req dropping before req_ack is a protocol violation; the latched request completes regardless.
REQ-029 Outside ACK: req_ack = 0, err = 0, rd = 0.

Reset
REQ-030 reset = 1 at an edge -> state IDLE, wait counter 0, req_ack 0, err 0, rd 0.
REQ-031 Reset during WAIT or ACK aborts the transaction: no write commits and no req_ack is issued.
REQ-032 Array contents are not reset.
REQ-033 reset has priority over req in the same cycle.

Structure
REQ-034 Package simple_mem_pkg holds the size enum, the FSM state enum, and a be_gen function (size, addr low bits, DW) returning byte enables.
REQ-035 Sub-module simple_mem_array: DEPTH x DW byte-writeable synchronous RAM (we, be, index, wd, rd).
REQ-036 Top level: FSM, wait counter, request latch, range/alignment check, output muxing.

Verification
REQ-037 WAIT=0, DW=32: write word 32'hDEADBEEF to 0x10, then read 0x10 -> req_ack 1 cycle after each req; rd = 32'hDEADBEEF; err = 0.
REQ-038 WAIT=3: read 0x0 with req rising in cycle 5 -> req_ack high only in cycle 9.
REQ-039 DW=32: byte write 8'hAA to 0x13 over word 32'h11223344 at 0x10 -> read 0x10 returns 32'hAA223344.
REQ-040 Half write to 0x11 -> err = 1, word unchanged. Read of 0x1000 with DEPTH=1024 -> err = 1, rd = 0. size = 3 with DW = 32 -> err = 1.
REQ-041 WAIT=2: write 32'h5555_5555 to 0x20 with reset pulsed in the WAIT state -> no req_ack; later read of 0x20 returns the old value.
REQ-042 DW=64, BASE=32'h8000_0000: dword write 64'h0123_4567_89AB_CDEF to 0x8000_0008, then read -> same value, err = 0.

Source files
------------

// File: rtl/simple_mem_pkg.sv
// Shared types and byte-enable helper for the simple memory slave.
package simple_mem_pkg;

    typedef enum logic [1:0] {
        SzByte  = 2'd0,
        SzHalf  = 2'd1,
        SzWord  = 2'd2,
        SzDword = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAck
    } state_e;

    // Byte enables for an access of 2^size bytes at the lane selected by the low address bits.
    function automatic logic [7:0] be_gen(input logic [1:0] size, input logic [2:0] addr_lo,
                                          input int unsigned dw);
        logic [7:0] mask;
        logic [2:0] lane;
        lane = (dw == 64) ? addr_lo : {1'b0, addr_lo[1:0]};
        unique case (size_e'(size))
            SzByte:  mask = 8'h01;
            SzHalf:  mask = 8'h03;
            SzWord:  mask = 8'h0F;
            SzDword: mask = 8'hFF;
        endcase
        return mask << lane;
    endfunction

endpackage

// File: rtl/simple_mem_array.sv
// DEPTH x DW synchronous RAM with per-byte write enables and a registered read port.
module simple_mem_array #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [DW/8-1:0]          be_i,
    input  logic [$clog2(DEPTH)-1:0] idx_i,
    input  logic [DW-1:0]            wd_i,
    output logic [DW-1:0]            rd_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rd_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < DW / 8; b++) begin
                if (be_i[b]) begin
                    mem_q[idx_i][8*b +: 8] <= wd_i[8*b +: 8];
                end
            end
        end
        rd_q <= mem_q[idx_i];
    end

    assign rd_o = rd_q;

endmodule

// File: rtl/simple_mem_slave.sv
// Request/acknowledge memory slave: FSM with optional wait states, range and alignment checks.
module simple_mem_slave
    import simple_mem_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned WAIT  = 0,
    parameter logic [31:0] BASE  = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   addr,
    input  logic [DW-1:0] wd,
    input  logic          we,
    input  logic [1:0]    size,
    input  logic          req,
    output logic [DW-1:0] rd,
    output logic          req_ack,
    output logic          err
);

    localparam int unsigned     NB       = DW / 8;
    localparam int unsigned     ByteSh   = $clog2(NB);
    localparam int unsigned     IdxW     = $clog2(DEPTH);
    localparam longint unsigned MemBytes = longint'(DEPTH) * NB;
    localparam logic [3:0]      WaitInit = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, err_q;
    logic [IdxW-1:0]   idx_q;
    logic [DW-1:0]     wd_q;
    logic [NB-1:0]     be_q;

    logic [31:0]       offset;
    logic [IdxW-1:0]   req_idx;
    logic              misalign, req_err, accept;
    logic [7:0]        be_full;
    logic              unused_be;
    logic [IdxW-1:0]   mem_idx;
    logic              mem_we;
    logic [DW-1:0]     mem_rd;

    always_comb begin
        offset  = addr - BASE;
        req_idx = offset[ByteSh +: IdxW];
        unique case (size)
            2'd0:    misalign = 1'b0;
            2'd1:    misalign = addr[0];
            2'd2:    misalign = |addr[1:0];
            default: misalign = |addr[2:0];
        endcase
        req_err = ({32'd0, offset} >= MemBytes) | misalign | ((size == 2'd3) && (DW == 32));
        be_full = be_gen(size, addr[2:0], DW);
    end

    // Only the low NB enables are meaningful for the configured width.
    assign unused_be = ^be_full;
    assign accept    = (state_q == StIdle) && req;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (WAIT > 0) begin
                        state_d = StWait;
                        cnt_d   = WaitInit;
                    end else begin
                        state_d = StAck;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StAck;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            we_q  <= we;
            err_q <= req_err;
            idx_q <= req_idx;
            wd_q  <= wd;
            be_q  <= be_full[NB-1:0];
        end
    end

    // In IDLE the RAM reads the live index so a zero-wait read is ready in the ACK cycle.
    assign mem_idx = (state_q == StIdle) ? req_idx : idx_q;
    assign mem_we  = (state_q == StAck) && we_q && !err_q && !reset;

    simple_mem_array #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_array (
        .clk_i (clk),
        .we_i  (mem_we),
        .be_i  (be_q),
        .idx_i (mem_idx),
        .wd_i  (wd_q),
        .rd_o  (mem_rd)
    );

    assign req_ack = (state_q == StAck);
    assign err     = req_ack && err_q;
    assign rd      = (req_ack && !err_q) ? mem_rd : '0;

endmodule

// File: tb/tb_simple_mem_slave.sv
// Directed plus random bench for simple_mem_slave against a byte-array reference model.
module tb_simple_mem_slave;

    localparam logic [31:0] BaseA = 32'h0000_0000;
    localparam logic [31:0] BaseB = 32'h8000_0000;
    localparam int          WaitA = 0;
    localparam int          WaitB = 3;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic [31:0] addr;
    logic [63:0] wd;
    logic        we;
    logic [1:0]  size;
    logic        req_a, req_b;
    logic [31:0] rd_a;
    logic [63:0] rd_b;
    logic        ack_a, ack_b, err_a, err_b;

    int errors = 0;
    int checks = 0;

    logic [7:0] mdl [2][4096];

    always #5 clk = ~clk;

    simple_mem_slave #(
        .DW    (32),
        .DEPTH (1024),
        .WAIT  (WaitA),
        .BASE  (BaseA)
    ) dut_a (
        .clk     (clk),
        .reset   (rst_a),
        .addr    (addr),
        .wd      (wd[31:0]),
        .we      (we),
        .size    (size),
        .req     (req_a),
        .rd      (rd_a),
        .req_ack (ack_a),
        .err     (err_a)
    );

    simple_mem_slave #(
        .DW    (64),
        .DEPTH (256),
        .WAIT  (WaitB),
        .BASE  (BaseB)
    ) dut_b (
        .clk     (clk),
        .reset   (rst_b),
        .addr    (addr),
        .wd      (wd),
        .we      (we),
        .size    (size),
        .req     (req_b),
        .rd      (rd_b),
        .req_ack (ack_b),
        .err     (err_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic txn(input int which, input logic [31:0] a, input logic [63:0] d,
                       input logic w, input logic [1:0] sz,
                       output logic [63:0] r, output logic e);
        int lat;
        bit got;
        @(posedge clk);
        #1;
        addr = a; wd = d; we = w; size = sz;
        if (which == 0) req_a = 1'b1; else req_b = 1'b1;
        lat = 0;
        got = 0;
        r   = '0;
        e   = 1'b0;
        while (!got && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (which == 0 ? ack_a : ack_b) begin
                got = 1;
                r   = (which == 0) ? {32'd0, rd_a} : rd_b;
                e   = (which == 0) ? err_a : err_b;
                req_a = 1'b0;
                req_b = 1'b0;
            end
        end
        req_a = 1'b0;
        req_b = 1'b0;
        chk("ack_seen", 64'(got), 64'd1);
        chk("latency", 64'(lat), 64'((which == 0 ? WaitA : WaitB) + 1));
        @(posedge clk);
        #1;
        chk("ack_pulse", 64'(which == 0 ? ack_a : ack_b), 64'd0);
    endtask

    task automatic op(input int which, input logic [31:0] a, input logic [63:0] d,
                      input logic w, input logic [1:0] sz, output logic [63:0] r);
        logic [63:0]     exp_rd;
        logic            e;
        int              nb, lane, o;
        longint unsigned lim;
        logic [31:0]     off;
        bit              bad;
        nb  = (which == 0) ? 4 : 8;
        lim = (which == 0) ? 4096 : 2048;
        txn(which, a, d, w, sz, r, e);
        off = a - ((which == 0) ? BaseA : BaseB);
        bad = (longint'(off) >= lim) || ((a % (32'd1 << sz)) != 0) || (sz == 2'd3 && nb == 4);
        exp_rd = '0;
        if (!bad) begin
            o    = int'(off);
            lane = o % nb;
            for (int k = 0; k < nb; k++) exp_rd[8*k +: 8] = mdl[which][o - lane + k];
            if (w) begin
                for (int i = 0; i < (1 << sz); i++) mdl[which][o + i] = d[8*(lane + i) +: 8];
            end
        end
        chk("err", 64'(e), 64'(bad));
        if (bad || !w) chk("rd", r, exp_rd);
    endtask

    initial begin
        logic [63:0] r;
        int          acks;
        logic [31:0] a;
        int          which;

        rst_a = 1'b1; rst_b = 1'b1;
        req_a = 1'b0; req_b = 1'b0;
        addr = '0; wd = '0; we = 1'b0; size = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack_a", 64'(ack_a), 64'd0);
        chk("rst_err_a", 64'(err_a), 64'd0);
        chk("rst_rd_a", {32'd0, rd_a}, 64'd0);
        chk("rst_ack_b", 64'(ack_b), 64'd0);
        chk("rst_err_b", 64'(err_b), 64'd0);
        chk("rst_rd_b", rd_b, 64'd0);
        rst_a = 1'b0; rst_b = 1'b0;

        // Fill the model-tracked regions so every later read has defined data.
        for (int i = 0; i < 16; i++) op(0, BaseA + 32'(4 * i), {32'd0, $urandom}, 1'b1, 2'd2, r);
        for (int i = 0; i < 16; i++) op(1, BaseB + 32'(8 * i), {$urandom, $urandom}, 1'b1, 2'd3, r);

        op(0, 32'h10, 64'hDEAD_BEEF, 1'b1, 2'd2, r);
        op(0, 32'h10, 64'd0, 1'b0, 2'd2, r);
        chk("deadbeef", r, 64'hDEAD_BEEF);

        op(0, 32'h10, 64'h1122_3344, 1'b1, 2'd2, r);
        op(0, 32'h13, 64'hAA00_0000, 1'b1, 2'd0, r);
        op(0, 32'h10, 64'd0, 1'b0, 2'd2, r);
        chk("byte_merge", r, 64'hAA22_3344);

        op(0, 32'h11, 64'hFFFF_FFFF, 1'b1, 2'd1, r);
        op(0, 32'h10, 64'd0, 1'b0, 2'd2, r);
        chk("after_bad_half", r, 64'hAA22_3344);
        op(0, 32'h1000, 64'd0, 1'b0, 2'd2, r);
        op(0, 32'h10, 64'd0, 1'b0, 2'd3, r);

        op(1, BaseB, 64'd0, 1'b0, 2'd3, r);
        op(1, BaseB + 32'h8, 64'h0123_4567_89AB_CDEF, 1'b1, 2'd3, r);
        op(1, BaseB + 32'h8, 64'd0, 1'b0, 2'd3, r);
        chk("dword_rt", r, 64'h0123_4567_89AB_CDEF);

        // Reset pulsed while the write sits in wait states must abort it silently.
        op(1, BaseB + 32'h20, 64'h0BAD_F00D_CAFE_0001, 1'b1, 2'd3, r);
        @(posedge clk);
        #1;
        addr = BaseB + 32'h20; wd = 64'h5555_5555; we = 1'b1; size = 2'd2; req_b = 1'b1;
        acks = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (ack_b) acks++;
            if (c == 1) begin
                rst_b = 1'b1;
                req_b = 1'b0;
            end else if (c == 2) begin
                rst_b = 1'b0;
            end
        end
        chk("abort_no_ack", 64'(acks), 64'd0);
        op(1, BaseB + 32'h20, 64'd0, 1'b0, 2'd3, r);
        chk("abort_old", r, 64'h0BAD_F00D_CAFE_0001);

        for (int n = 0; n < 120; n++) begin
            which = n % 2;
            if ($urandom_range(0, 7) == 0) begin
                a = (which == 0) ? BaseA + 32'd4096 + $urandom_range(0, 31)
                                 : BaseB - 32'd1 - $urandom_range(0, 31);
            end else begin
                a = (which == 0) ? BaseA + $urandom_range(0, 63) : BaseB + $urandom_range(0, 127);
            end
            op(which, a, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)), r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
